// File: rtl/vid_frame_arbiter.sv
// Frame-granular round-robin arbiter: shares one downscaler datapath between two
// video streams, granting only at SOF and holding the grant for exactly LINES lines.
module vid_frame_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int LINES   = 4,
  parameter int LC_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] s0_data,
  input  logic               s0_valid,
  input  logic               s0_tlast,
  input  logic               s0_tuser,
  output logic               s0_ready,
  input  logic [D_WIDTH-1:0] s1_data,
  input  logic               s1_valid,
  input  logic               s1_tlast,
  input  logic               s1_tuser,
  output logic               s1_ready,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  output logic               m_tlast,
  output logic               m_tuser,
  input  logic               m_ready,
  output logic               grant_id,
  output logic               busy,
  output logic               err_early_sof
);

  if (LINES < 2 || LINES >= 2**LC_W) begin : g_bad_param
    $error("vid_frame_arbiter: need LINES >= 2 and 2**LC_W > LINES");
  end

  typedef enum logic {ARB, GRANT} state_t;

  state_t          state, state_nxt;
  logic            grant_id_nxt, last_grant, last_grant_nxt;
  logic [LC_W-1:0] line_cnt, line_cnt_nxt;
  logic            first_beat, first_beat_nxt;
  logic            err_nxt;
  logic            req0, req1, win, xfer;

  assign req0 = s0_valid & s0_tuser;
  assign req1 = s1_valid & s1_tuser;
  // on a tie the source that did not win last time goes first
  assign win  = (req0 & req1) ? ~last_grant : req1;
  assign busy = (state == GRANT);

  always_comb begin
    state_nxt      = state;
    grant_id_nxt   = grant_id;
    last_grant_nxt = last_grant;
    line_cnt_nxt   = line_cnt;
    first_beat_nxt = first_beat;
    err_nxt        = 1'b0;
    xfer           = 1'b0;
    // discard rule: drop mid-frame beats, hold SOF beats
    s0_ready       = s0_valid & ~s0_tuser;
    s1_ready       = s1_valid & ~s1_tuser;
    m_data         = '0;
    m_valid        = 1'b0;
    m_tlast        = 1'b0;
    m_tuser        = 1'b0;

    if (state == ARB) begin
      if (req0 | req1) begin
        state_nxt      = GRANT;
        grant_id_nxt   = win;
        last_grant_nxt = win;
        line_cnt_nxt   = '0;
        first_beat_nxt = 1'b1;
      end
    end else begin
      if (grant_id) begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        m_tlast  = s1_tlast;
        m_tuser  = s1_tuser;
        s1_ready = m_ready;
      end else begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        m_tlast  = s0_tlast;
        m_tuser  = s0_tuser;
        s0_ready = m_ready;
      end
      xfer = m_valid & m_ready;
      if (xfer) begin
        first_beat_nxt = 1'b0;
        if (m_tuser && !first_beat) begin
          // restart the frame from this beat, same source keeps the grant
          err_nxt      = 1'b1;
          line_cnt_nxt = {{(LC_W-1){1'b0}}, m_tlast};
        end else if (m_tlast) begin
          if (line_cnt == LC_W'(LINES-1)) begin
            state_nxt    = ARB;
            line_cnt_nxt = '0;
          end else begin
            line_cnt_nxt = line_cnt + LC_W'(1);
          end
        end
      end
    end

    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      m_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      grant_id      <= 1'b0;
      last_grant    <= 1'b1;
      line_cnt      <= '0;
      first_beat    <= 1'b0;
      err_early_sof <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant_id      <= grant_id_nxt;
      last_grant    <= last_grant_nxt;
      line_cnt      <= line_cnt_nxt;
      first_beat    <= first_beat_nxt;
      err_early_sof <= err_nxt;
    end
  end

endmodule

// File: tb/tb_vid_frame_arbiter.sv
// Randomized bench for vid_frame_arbiter: two stream sources driven from beat queues,
// checked every cycle against a frame-level reference model.
module tb_vid_frame_arbiter;
  localparam int DW = 8, LINES = 4, LC_W = 12, W = 3, NCYC = 4000;

  logic clk = 0, rst = 1;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic s0_valid, s0_tlast, s0_tuser, s0_ready;
  logic s1_valid, s1_tlast, s1_tuser, s1_ready;
  logic m_valid, m_tlast, m_tuser, m_ready;
  logic grant_id, busy, err_early_sof;

  vid_frame_arbiter #(.D_WIDTH(DW), .LINES(LINES), .LC_W(LC_W)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .err_early_sof(err_early_sof));

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] d; logic l; logic u;} beat_t;
  beat_t q0[$], q1[$];
  int n_tests = 0, n_fail = 0;
  logic [6:0] seq [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(int s, beat_t b);
    if (s == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  // one frame of LINES x W beats, optionally preceded by junk and with an early SOF
  task automatic push_frame(int s, bit rnd);
    beat_t b;
    int early = -1;
    int junk = rnd ? $urandom_range(0, 3) : 0;
    if (rnd && $urandom_range(0, 4) == 0) early = $urandom_range(1, LINES*W-1);
    for (int j = 0; j < junk; j++) begin
      b.d = {s[0], seq[s]}; seq[s]++; b.u = 0; b.l = ($urandom_range(0, 2) == 0);
      push(s, b);
    end
    for (int k = 0; k < LINES*W; k++) begin
      b.d = {s[0], seq[s]}; seq[s]++;
      b.u = (k == 0) || (k == early);
      b.l = (k % W == W-1);
      push(s, b);
    end
  endtask

  // reference model: owner of the datapath (-1 = none) and lines completed in the frame
  int own = -1, gid = 0, lastg = 1, lines = 0, fresh = 0, err = 0;
  int n_own, n_gid, n_lastg, n_lines, n_fresh, n_err;
  int mdl_frames = 0, dut_frames = 0, mdl_errs = 0, dut_errs = 0;
  logic [1:0] v, u, l, hs, er;
  logic [DW-1:0] d [2];
  logic busy_q = 0;
  int gap = 0;
  bit rnd = 0;

  initial begin
    beat_t b;
    logic e_mv, e_ml, e_mu;
    logic [DW-1:0] e_md;
    int win;
    seq[0] = 0; seq[1] = 0;
    v = 0; u = 0; l = 0; hs = 0; d[0] = 0; d[1] = 0; m_ready = 1;
    push_frame(0, 0); push_frame(1, 0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      own = n_own; gid = n_gid; lastg = n_lastg; lines = n_lines; fresh = n_fresh; err = n_err;
      if (cyc > 0) begin
        if (busy && !busy_q) dut_frames++;
        busy_q = busy;
      end
      #1;
      rst = (cyc < 4) || (cyc >= 2000 && cyc < 2003);
      if (cyc == 300) begin rnd = 1; gap = 30; end
      m_ready = (cyc < 300) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (hs[0]) void'(q0.pop_front());
      if (hs[1]) void'(q1.pop_front());
      if (q0.size() < 4) push_frame(0, rnd);
      if (q1.size() < 4) push_frame(1, rnd);
      // a presented beat stays put until it is taken
      for (int s = 0; s < 2; s++) begin
        b = (s == 0) ? q0[0] : q1[0];
        if (!(v[s] && !hs[s])) v[s] = ($urandom_range(0, 99) >= gap);
        d[s] = b.d; u[s] = b.u; l[s] = b.l;
      end
      s0_valid = v[0]; s0_data = d[0]; s0_tuser = u[0]; s0_tlast = l[0];
      s1_valid = v[1]; s1_data = d[1]; s1_tuser = u[1]; s1_tlast = l[1];

      @(negedge clk);
      er = 0; e_mv = 0; e_md = 0; e_ml = 0; e_mu = 0;
      if (!rst) begin
        for (int s = 0; s < 2; s++) er[s] = v[s] && !u[s];
        if (own >= 0) begin
          er[own] = m_ready;
          e_mv = v[own]; e_md = d[own]; e_ml = l[own]; e_mu = u[own];
        end
      end
      chk("s0_ready", s0_ready, er[0]);
      chk("s1_ready", s1_ready, er[1]);
      chk("m_valid", m_valid, e_mv);
      chk("busy", busy, own >= 0);
      chk("grant_id", grant_id, gid);
      chk("err_early_sof", err_early_sof, err);
      if (e_mv) begin
        chk("m_data", m_data, e_md);
        chk("m_tlast", m_tlast, e_ml);
        chk("m_tuser", m_tuser, e_mu);
      end
      if (err_early_sof) dut_errs++;
      hs[0] = s0_valid && s0_ready;
      hs[1] = s1_valid && s1_ready;

      n_own = own; n_gid = gid; n_lastg = lastg; n_lines = lines; n_fresh = fresh; n_err = 0;
      if (rst) begin
        n_own = -1; n_gid = 0; n_lastg = 1; n_lines = 0; n_fresh = 0;
      end else if (own < 0) begin
        win = -1;
        if (v[0] && u[0] && v[1] && u[1]) win = 1 - lastg;
        else if (v[0] && u[0]) win = 0;
        else if (v[1] && u[1]) win = 1;
        if (win >= 0) begin
          n_own = win; n_gid = win; n_lastg = win; n_lines = 0; n_fresh = 1;
          mdl_frames++;
        end
      end else if (v[own] && m_ready) begin
        n_fresh = 0;
        if (u[own] && !fresh) begin
          n_err = 1; mdl_errs++;
          n_lines = l[own] ? 1 : 0;
        end else if (l[own]) begin
          n_lines = lines + 1;
          if (n_lines == LINES) begin n_own = -1; n_lines = 0; end
        end
      end
    end
    chk("grant_count", dut_frames, mdl_frames);
    chk("early_sof_count", dut_errs, mdl_errs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    n_own = -1; n_gid = 0; n_lastg = 1; n_lines = 0; n_fresh = 0; n_err = 0;
  end
endmodule

// File: doc/vid_frame_arbiter.md
# vid_frame_arbiter

Frame-granular round-robin arbiter that shares one 2x2 downscaler datapath between two independent video streams. Both sources use the same stream convention as the downscaler: data/valid/ready plus tlast (end of line) and tuser (start of frame). A grant is issued only at a start of frame and held for exactly LINES lines, so the downstream decimation counters always see whole frames from a single source. Non-granted sources are resynchronised by discarding their mid-frame beats.

## Interface
- D_WIDTH, 8, pixel data width
- LINES, 4, lines per frame; must be ≥ 2
- LC_W, 12, line-counter width; must satisfy 2^LC_W > LINES
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s0_data  in  D_WIDTH  source 0 pixel
- s0_valid / s0_tlast / s0_tuser  in  1 each  source 0 valid, end-of-line, start-of-frame
- s0_ready  out  1  source 0 ready
- s1_data, s1_valid, s1_tlast, s1_tuser, s1_ready: same as source 0, for source 1
- m_data  out  D_WIDTH  to downscaler
- m_valid / m_tlast / m_tuser  out  1 each  to downscaler
- m_ready  in  1  from downscaler
- grant_id  out  1  source currently or last granted
- busy  out  1  high while in GRANT
- err_early_sof  out  1  one-cycle pulse on an unexpected SOF inside a granted frame

## Operation
- States: ARB and GRANT. Registers: state, grant_id, last_grant, line_cnt[LC_W-1:0].
- A source requests when sN_valid & sN_tuser.
- ARB:
  - m_valid = 0.
  - For each source, sN_ready = sN_valid & ~sN_tuser. Non-SOF beats are discarded; SOF beats are held.
  - If exactly one source requests, it is granted. If both request, the source ≠ last_grant is granted.
  - On a grant: grant_id and last_grant take the winner, line_cnt = 0, next state = GRANT.
- GRANT, granted source g:
  - m_data/m_valid/m_tlast/m_tuser = sg_*, combinational pass-through.
  - sg_ready = m_ready.
  - The other source uses the ARB discard rule (its SOF is held, everything else is dropped).
- Handshake: a beat transfers when m_valid & m_ready.
- Line counting: a transferred beat with tlast increments line_cnt. A transferred tlast beat with line_cnt == LINES-1 ends the frame: next state = ARB, line_cnt = 0.
- Early SOF: a transferred beat with tuser = 1 that is not the first beat of the grant does the following:
  - pulses err_early_sof;
  - sets line_cnt = 0, or 1 if that same beat also has tlast;
  - keeps the grant, treating the beat as the start of a new frame from the same source.
- Unterminated frames are not timed out. A stalled granted source holds the datapath indefinitely.
- Reset, including mid-frame: state = ARB, grant_id = 0, last_grant = 1 (source 0 wins the first tie), line_cnt = 0, busy = 0, err_early_sof = 0. While rst = 1, s0_ready = s1_ready = 0 and m_valid = 0. Any partial frame is abandoned; the downscaler must be reset with the same rst.

## Timing
- Datapath latency in GRANT: 0 cycles, combinational. No data registers.
- Arbitration overhead: 1 cycle.
  - A request seen in ARB at cycle t gives m_valid from cycle t+1, with the held SOF beat as the first output.
  - After a frame-ending handshake at cycle t, state is ARB at t+1 and the next grant is effective at t+2.
- busy = (state == GRANT), registered. grant_id changes only on the ARB→GRANT transition.
- err_early_sof is registered and asserts the cycle after the offending handshake.
- m_ready low freezes line_cnt and state. Once the selected source asserts sg_valid, it must hold it and its data stable until the beat transfers.
- A frame-end and a new request on the other source in the same cycle: the request is evaluated in ARB at the next cycle, and round-robin applies.
- line_cnt never wraps in legal operation. The LC_W constraint is checked by an elaboration assertion.

## Test plan
1. Single source, LINES=4, 3 pixels/line, s0 frame only, m_ready=1 → 12 beats out with m_tuser on beat 1 and m_tlast on beats 3/6/9/12. grant_id=0, busy high for 12 cycles, then ARB.
2. Both sources present SOF in the same cycle after reset → s0 is granted first. After s0's 4 lines, s1 is granted 2 cycles after the s0 frame end. Further simultaneous requests alternate 0, 1, 0, 1.
3. s1 starts streaming mid-frame (3 non-SOF beats, then SOF) while s0 is granted → the 3 beats are accepted with s1_ready=1 and dropped. The SOF is held with s1_ready=0 until s0's frame ends, then s1 is granted and its SOF is the first m_ data.
4. Random m_ready backpressure (~50%) during an s1 frame → output beat order and values are identical to source order, line_cnt only advances on handshakes, and no beat is lost or duplicated.
5. s0 sends tuser on the 5th beat of a granted frame → err_early_sof pulses once, line_cnt resets, and the grant ends 4 lines after that beat.
6. rst asserted mid-line during GRANT → the next cycle shows busy=0, m_valid=0, grant_id=0, and both readies 0 while rst is high. After release, the first SOF is granted normally.
